// File: rtl/ninjin_pkg.sv
// ninjin_pkg: FSM state encodings, AXI burst/cache constants and clogb2 shared by the ninjin AXI masters
package ninjin_pkg;
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_RESP = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [3:0] AXI_CACHE_MOD = 4'b0010;
   function automatic int clogb2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction
endpackage

// File: rtl/ninjin_m_axi_multi_if.sv
// ninjin_m_axi_multi_if: AXI4 AW/W/B/AR/R bus between a ninjin master and the DDR slave
interface ninjin_m_axi_multi_if #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
);
   logic              awid;
   logic [AWIDTH-1:0] awaddr;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              awlock;
   logic [3:0]        awcache;
   logic [2:0]        awprot;
   logic [3:0]        awqos;
   logic              awuser;
   logic              awvalid;
   logic              awready;
   logic [DWIDTH-1:0] wdata;
   logic [DWIDTH/8-1:0] wstrb;
   logic              wlast;
   logic              wuser;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic              arid;
   logic [AWIDTH-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arlock;
   logic [3:0]        arcache;
   logic [2:0]        arprot;
   logic [3:0]        arqos;
   logic              aruser;
   logic              arvalid;
   logic              arready;
   logic [DWIDTH-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;
   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
      output wdata, wstrb, wlast, wuser, wvalid, bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
   );
   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
      input  wdata, wstrb, wlast, wuser, wvalid, bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/ninjin_axi_burst_split.sv
// ninjin_axi_burst_split: tracks remaining beats and the next burst address, sizing each burst to BURST_MAX
module ninjin_axi_burst_split import ninjin_pkg::*; #(
   parameter int BURST_MAX = 16,
   parameter int DWIDTH    = 32,
   parameter int AWIDTH    = 32,
   parameter int LWIDTH    = 16
) (
   input  logic              clk,
   input  logic              xrst,
   input  logic              load,
   input  logic [AWIDTH-1:0] base,
   input  logic [LWIDTH-1:0] len,
   input  logic              next,
   output logic [AWIDTH-1:0] addr,
   output logic [LWIDTH:0]   blen,
   output logic              last
);
   localparam int SHIFT = clogb2(DWIDTH / 8);
   localparam logic [LWIDTH:0] BMAX = (LWIDTH + 1)'(BURST_MAX);
   logic [LWIDTH:0]   rem_q, rem_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   assign blen = rem_q > BMAX ? BMAX : rem_q;
   assign last = rem_q <= BMAX;
   assign addr = addr_q;
   // reload on a new request, step past the finished burst on next
   always_comb begin
      rem_d  = load ? {1'b0, len} : next ? rem_q - blen : rem_q;
      addr_d = load ? base : next ? addr_q + (AWIDTH'(blen) << SHIFT) : addr_q;
   end
   // remaining-beat and address registers
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         rem_q  <= '0;
         addr_q <= '0;
      end else begin
         rem_q  <= rem_d;
         addr_q <= addr_d;
      end
   end
endmodule

// File: rtl/ninjin_m_axi_multi.sv
// ninjin_m_axi_multi: multi-burst AXI4 DDR read/write master; define NINJIN_AXI_ERR_EN to report bresp/rresp errors and abort
module ninjin_m_axi_multi import ninjin_pkg::*; #(
   parameter int BURST_MAX = 16,
   parameter int DWIDTH    = 32,
   parameter int AWIDTH    = 32,
   parameter int LWIDTH    = 16
) (
   input  logic              clk,
   input  logic              xrst,
   input  logic              ddr_req,
   input  logic              ddr_mode,
   input  logic [AWIDTH-1:0] ddr_base,
   input  logic [LWIDTH-1:0] ddr_len,
   input  logic [DWIDTH-1:0] ddr_wdata,
   input  logic              ddr_wvalid,
   output logic              ddr_wready,
   output logic [DWIDTH-1:0] ddr_rdata,
   output logic              ddr_rvalid,
   output logic              ddr_busy,
   output logic              ddr_done,
   output logic [1:0]        err,
   ninjin_m_axi_multi_if.master m_axi
);
   localparam logic [2:0] SIZE = 3'(clogb2(DWIDTH / 8));
   logic [2:0]        state_q, state_d;
   logic              mode_q, mode_d;
   logic [LWIDTH:0]   beat_q, beat_d, blen;
   logic [1:0]        err_q, err_d, err_new;
   logic [AWIDTH-1:0] addr;
   logic load, next, last, stop, in_addr, in_wdata, in_rdata;
   logic aw_hs, ar_hs, w_hs, b_hs, r_hs, unused_resp;
   assign load     = state_q == S_IDLE && ddr_req;
   assign in_addr  = state_q == S_ADDR;
   assign in_wdata = state_q == S_DATA && mode_q;
   assign in_rdata = state_q == S_DATA && !mode_q;
   ninjin_axi_burst_split #(.BURST_MAX(BURST_MAX), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .LWIDTH(LWIDTH)) u_split (
      .clk(clk), .xrst(xrst), .load(load), .base(ddr_base), .len(ddr_len),
      .next(next), .addr(addr), .blen(blen), .last(last)
   );
   assign m_axi.awid    = 1'b0;
   assign m_axi.awaddr  = addr;
   assign m_axi.awlen   = 8'(blen - 1'b1);
   assign m_axi.awsize  = SIZE;
   assign m_axi.awburst = AXI_BURST_INCR;
   assign m_axi.awlock  = 1'b0;
   assign m_axi.awcache = AXI_CACHE_MOD;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.awqos   = 4'b0000;
   assign m_axi.awuser  = 1'b0;
   assign m_axi.awvalid = in_addr && mode_q;
   assign m_axi.wdata   = ddr_wdata;
   assign m_axi.wstrb   = '1;
   assign m_axi.wlast   = in_wdata && beat_q == blen - 1'b1;
   assign m_axi.wuser   = 1'b0;
   assign m_axi.wvalid  = in_wdata && ddr_wvalid;
   assign m_axi.bready  = state_q == S_RESP;
   assign m_axi.arid    = 1'b0;
   assign m_axi.araddr  = addr;
   assign m_axi.arlen   = 8'(blen - 1'b1);
   assign m_axi.arsize  = SIZE;
   assign m_axi.arburst = AXI_BURST_INCR;
   assign m_axi.arlock  = 1'b0;
   assign m_axi.arcache = AXI_CACHE_MOD;
   assign m_axi.arprot  = 3'b000;
   assign m_axi.arqos   = 4'b0000;
   assign m_axi.aruser  = 1'b0;
   assign m_axi.arvalid = in_addr && !mode_q;
   assign m_axi.rready  = in_rdata;
   assign ddr_wready = in_wdata && m_axi.wready;
   assign ddr_rvalid = m_axi.rvalid && m_axi.rready;
   assign ddr_rdata  = m_axi.rdata;
   assign ddr_busy   = state_q != S_IDLE;
   assign ddr_done   = state_q == S_DONE;
   assign err        = err_q;
   assign aw_hs = m_axi.awvalid && m_axi.awready;
   assign ar_hs = m_axi.arvalid && m_axi.arready;
   assign w_hs  = m_axi.wvalid && m_axi.wready;
   assign b_hs  = m_axi.bvalid && m_axi.bready;
   assign r_hs  = m_axi.rvalid && m_axi.rready;
   assign next  = b_hs || (r_hs && m_axi.rlast);
   assign stop  = last || |err_d;
`ifdef NINJIN_AXI_ERR_EN
   assign err_new     = {b_hs && m_axi.bresp[1], r_hs && m_axi.rresp[1]};
   assign unused_resp = ^{m_axi.bresp[0], m_axi.rresp[0]};
`else
   assign err_new     = 2'b00;
   assign unused_resp = ^{m_axi.bresp, m_axi.rresp};
`endif
   // transfer sequencing: one burst in flight, address -> data -> (write) response -> next or done
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      beat_d  = beat_q;
      err_d   = load ? 2'b00 : err_q | err_new;
      case (state_q)
         S_IDLE: if (ddr_req) begin
            mode_d  = ddr_mode;
            state_d = ddr_len == '0 ? S_DONE : S_ADDR;
         end
         S_ADDR: if (aw_hs || ar_hs) begin
            beat_d  = '0;
            state_d = S_DATA;
         end
         S_DATA: if (w_hs) begin
            beat_d  = beat_q + 1'b1;
            state_d = m_axi.wlast ? S_RESP : S_DATA;
         end else if (r_hs && m_axi.rlast) begin
            state_d = stop ? S_DONE : S_ADDR;
         end
         S_RESP: if (b_hs) state_d = stop ? S_DONE : S_ADDR;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   // state, mode, beat counter and sticky error registers
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state_q <= S_IDLE;
         mode_q  <= 1'b0;
         beat_q  <= '0;
         err_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_ninjin_m_axi_multi.sv
// tb_ninjin_m_axi_multi: directed bench for ninjin_m_axi_multi with a small AXI slave and DDR stream source
module tb_ninjin_m_axi_multi;
   logic        clk, xrst, ddr_req, ddr_mode;
   logic [31:0] ddr_base;
   logic [15:0] ddr_len;
   logic [31:0] ddr_wdata, ddr_rdata;
   logic        ddr_wvalid, ddr_wready, ddr_rvalid, ddr_busy, ddr_done;
   logic [1:0]  err;
   int n_vec = 0, n_bad = 0;
   int cyc = 0, n_aw = 0, n_ar = 0, n_w = 0, n_b = 0, n_rv = 0, n_done = 0, n_wl = 0, n_any = 0;
   int w_bad = 0, rd_bad = 0, aw_unstable = 0, aw_wait = 0, aw_wait_max = 0;
   int done_cyc = 0, rlast_cyc = 0, req_cyc = 0;
   logic [31:0] aw_addr_a [64];
   int          aw_len_a [64];
   int          wl_at [64];
   logic [31:0] ar_addr_last, aw_prev;
   int          ar_len_last;
   logic [8:0]  aw_attr;
   logic hs_aw = 0, hs_ar = 0, hs_w = 0, hs_wl = 0, hs_b = 0, hs_r = 0;
   int aw_delay = 0, err_burst = -1, b_idx = 0, w_seq = 0, r_seq = 0, b_owed = 0, r_left = 0, aw_cnt = 0;
   logic r_gaps = 0, w_toggle = 0;

   ninjin_m_axi_multi_if #(.AWIDTH(32), .DWIDTH(32)) m_axi ();

   ninjin_m_axi_multi #(.BURST_MAX(16), .DWIDTH(32), .AWIDTH(32), .LWIDTH(16)) dut (
      .clk(clk), .xrst(xrst), .ddr_req(ddr_req), .ddr_mode(ddr_mode), .ddr_base(ddr_base),
      .ddr_len(ddr_len), .ddr_wdata(ddr_wdata), .ddr_wvalid(ddr_wvalid), .ddr_wready(ddr_wready),
      .ddr_rdata(ddr_rdata), .ddr_rvalid(ddr_rvalid), .ddr_busy(ddr_busy), .ddr_done(ddr_done),
      .err(err), .m_axi(m_axi)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // monitor: sample everything mid-cycle, flag the handshakes of the coming edge
   always @(negedge clk) begin
      cyc++;
      hs_aw = m_axi.awvalid && m_axi.awready;
      hs_ar = m_axi.arvalid && m_axi.arready;
      hs_w  = m_axi.wvalid && m_axi.wready;
      hs_wl = hs_w && m_axi.wlast;
      hs_b  = m_axi.bvalid && m_axi.bready;
      hs_r  = m_axi.rvalid && m_axi.rready;
      if (m_axi.awvalid) begin
         if (aw_wait > 0 && m_axi.awaddr !== aw_prev) aw_unstable++;
         aw_prev = m_axi.awaddr;
      end
      aw_wait = (m_axi.awvalid && !m_axi.awready) ? aw_wait + 1 : 0;
      if (aw_wait > aw_wait_max) aw_wait_max = aw_wait;
      if (hs_aw) begin
         aw_addr_a[n_aw] = m_axi.awaddr;
         aw_len_a[n_aw] = int'(m_axi.awlen);
         aw_attr = {m_axi.awsize, m_axi.awburst, m_axi.awcache};
         n_aw++;
      end
      if (hs_ar) begin
         ar_addr_last = m_axi.araddr;
         ar_len_last = int'(m_axi.arlen);
         n_ar++;
      end
      if (hs_w) begin
         if (m_axi.wdata !== 32'hD000_0000 + 32'(n_w) || m_axi.wstrb !== 4'hF) w_bad++;
         n_w++;
         if (m_axi.wlast) begin
            wl_at[n_wl] = n_w;
            n_wl++;
         end
      end
      if (hs_b) n_b++;
      if (ddr_rvalid !== hs_r) rd_bad++;
      if (ddr_rvalid) begin
         if (ddr_rdata !== 32'hA000_0000 + 32'(n_rv)) rd_bad++;
         n_rv++;
      end
      if (hs_r && m_axi.rlast) rlast_cyc = cyc;
      if (ddr_done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (ddr_req && !ddr_busy && xrst) req_cyc = cyc;
      if (m_axi.awvalid || m_axi.arvalid || m_axi.wvalid) n_any++;
   end

   // AXI slave and DDR write source, updated just after each rising edge
   initial begin
      m_axi.awready = 0; m_axi.arready = 0; m_axi.wready = 1; m_axi.bvalid = 0; m_axi.bresp = 0;
      m_axi.rvalid = 0; m_axi.rdata = 0; m_axi.rresp = 0; m_axi.rlast = 0;
      ddr_wvalid = 0; ddr_wdata = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!xrst) begin
            b_owed = 0; r_left = 0; aw_cnt = 0;
            m_axi.awready = 0; m_axi.arready = 0; m_axi.bvalid = 0; m_axi.rvalid = 0; m_axi.rlast = 0;
            ddr_wvalid = 0;
         end else begin
            aw_cnt = m_axi.awvalid ? aw_cnt + 1 : 0;
            m_axi.awready = m_axi.awvalid && aw_cnt > aw_delay;
            m_axi.arready = m_axi.arvalid;
            if (hs_w) w_seq++;
            ddr_wvalid = w_toggle ? ~ddr_wvalid : 1'b1;
            ddr_wdata = 32'hD000_0000 + 32'(w_seq);
            if (hs_wl) b_owed++;
            if (hs_b) begin
               m_axi.bvalid = 0;
               b_owed--;
            end
            if (!m_axi.bvalid && b_owed > 0) begin
               m_axi.bvalid = 1;
               m_axi.bresp = (b_idx == err_burst) ? 2'b10 : 2'b00;
               b_idx++;
            end
            if (hs_r) begin
               r_left--;
               r_seq++;
            end
            if (hs_ar) r_left += ar_len_last + 1;
            m_axi.rvalid = r_left > 0 && (!r_gaps || $urandom_range(1, 0) == 1);
            m_axi.rdata = 32'hA000_0000 + 32'(r_seq);
            m_axi.rlast = r_left == 1;
            m_axi.rresp = 2'b00;
         end
      end
   end

   task automatic do_req(input logic mode, input logic [31:0] base, input logic [15:0] len);
      @(posedge clk);
      #1;
      ddr_req = 1; ddr_mode = mode; ddr_base = base; ddr_len = len;
      @(posedge clk);
      #1;
      ddr_req = 0;
   endtask

   task automatic wait_done(input int d0);
      int k;
      k = 0;
      while (n_done == d0 && k < 600) begin
         @(negedge clk);
         #1;
         k++;
      end
      repeat (4) begin
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      int a0, w0, wl0, d0, b0, r0, rv0, y0;
      xrst = 0; ddr_req = 0; ddr_mode = 0; ddr_base = 0; ddr_len = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset outputs", {ddr_busy, ddr_done, err, ddr_wready, ddr_rvalid, m_axi.awvalid, m_axi.wvalid,
                            m_axi.wlast, m_axi.bready, m_axi.arvalid, m_axi.rready}, 0);
      chk("reset awaddr", m_axi.awaddr, 0);
      @(posedge clk);
      #1;
      xrst = 1;

      a0 = n_aw; w0 = n_w; wl0 = n_wl; d0 = n_done; b0 = n_b; r0 = n_ar;
      do_req(1, 32'h1000, 40);
      wait_done(d0);
      chk("wr40 aw count", n_aw - a0, 3);
      chk("wr40 aw addr0", aw_addr_a[a0], 32'h1000);
      chk("wr40 aw addr1", aw_addr_a[a0 + 1], 32'h1040);
      chk("wr40 aw addr2", aw_addr_a[a0 + 2], 32'h1080);
      chk("wr40 awlen0", aw_len_a[a0], 15);
      chk("wr40 awlen1", aw_len_a[a0 + 1], 15);
      chk("wr40 awlen2", aw_len_a[a0 + 2], 7);
      chk("wr40 size/burst/cache", aw_attr, {3'd2, 2'b01, 4'b0010});
      chk("wr40 w beats", n_w - w0, 40);
      chk("wr40 wlast count", n_wl - wl0, 3);
      chk("wr40 wlast beat a", wl_at[wl0] - w0, 16);
      chk("wr40 wlast beat b", wl_at[wl0 + 1] - w0, 32);
      chk("wr40 wlast beat c", wl_at[wl0 + 2] - w0, 40);
      chk("wr40 wdata", w_bad, 0);
      chk("wr40 b count", n_b - b0, 3);
      chk("wr40 no ar", n_ar - r0, 0);
      chk("wr40 done", n_done - d0, 1);
      chk("wr40 err", err, 0);

      r_gaps = 1;
      a0 = n_aw; d0 = n_done; r0 = n_ar; rv0 = n_rv;
      do_req(0, 32'h2000, 5);
      wait_done(d0);
      chk("rd5 ar count", n_ar - r0, 1);
      chk("rd5 araddr", ar_addr_last, 32'h2000);
      chk("rd5 arlen", ar_len_last, 4);
      chk("rd5 rvalid count", n_rv - rv0, 5);
      chk("rd5 rdata", rd_bad, 0);
      chk("rd5 done after rlast", done_cyc - rlast_cyc, 1);
      chk("rd5 done", n_done - d0, 1);
      chk("rd5 no aw", n_aw - a0, 0);
      r_gaps = 0;

      y0 = n_any; d0 = n_done;
      do_req(1, 32'h5000, 0);
      wait_done(d0);
      chk("len0 no traffic", n_any - y0, 0);
      chk("len0 done", n_done - d0, 1);
      chk("len0 done cycle", done_cyc - req_cyc, 1);

      aw_delay = 7; w_toggle = 1;
      a0 = n_aw; w0 = n_w; d0 = n_done; r0 = n_ar;
      do_req(1, 32'h3000, 20);
      repeat (3) @(posedge clk);
      do_req(0, 32'h9000, 4);
      wait_done(d0);
      repeat (10) @(negedge clk);
      #1;
      chk("slow aw count", n_aw - a0, 2);
      chk("slow aw addr1", aw_addr_a[a0 + 1], 32'h3040);
      chk("slow awlen1", aw_len_a[a0 + 1], 3);
      chk("slow aw wait", aw_wait_max, 7);
      chk("slow aw stable", aw_unstable, 0);
      chk("slow w beats", n_w - w0, 20);
      chk("slow wdata", w_bad, 0);
      chk("busy req ignored ar", n_ar - r0, 0);
      chk("busy req ignored done", n_done - d0, 1);
      chk("busy req ignored busy", ddr_busy, 0);
      aw_delay = 0; w_toggle = 0;

      w0 = n_w; d0 = n_done; rv0 = n_rv;
      do_req(1, 32'h4000, 8);
      for (int k = 0; k < 60 && n_w - w0 < 3; k++) begin
         @(negedge clk);
         #1;
      end
      chk("midreset beat 3 reached", n_w - w0 >= 3, 1);
      xrst = 0;
      #1;
      chk("midreset outputs", {ddr_busy, ddr_done, err, ddr_wready, ddr_rvalid, m_axi.awvalid, m_axi.wvalid,
                               m_axi.wlast, m_axi.bready, m_axi.arvalid, m_axi.rready}, 0);
      chk("midreset awaddr", m_axi.awaddr, 0);
      repeat (3) @(posedge clk);
      #1;
      xrst = 1;
      do_req(0, 32'h6000, 3);
      wait_done(d0);
      chk("after reset done", n_done - d0, 1);
      chk("after reset araddr", ar_addr_last, 32'h6000);
      chk("after reset rvalid count", n_rv - rv0, 3);
      chk("after reset rdata", rd_bad, 0);

      a0 = n_aw; w0 = n_w; d0 = n_done;
      err_burst = b_idx;
      do_req(1, 32'h1000, 40);
      wait_done(d0);
      err_burst = -1;
`ifdef NINJIN_AXI_ERR_EN
      chk("berr err", err, 2'b10);
      chk("berr aw count", n_aw - a0, 1);
      chk("berr w beats", n_w - w0, 16);
      chk("berr done", n_done - d0, 1);
      d0 = n_done;
      do_req(0, 32'h7000, 1);
      wait_done(d0);
      chk("berr cleared", err, 2'b00);
`else
      chk("bresp ignored err", err, 2'b00);
      chk("bresp ignored aw count", n_aw - a0, 3);
      chk("bresp ignored w beats", n_w - w0, 40);
      chk("bresp ignored done", n_done - d0, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
